// File: rtl/atan2_seq.sv
// atan2_seq: sequential four-quadrant arctangent.
// The operands are folded into the first octant, and q = min/max is computed in
// Q1.14 with a restoring divider. The arctangent of q comes from an external
// combinational unit. The octant and quadrant folding is then undone to give
// atan2(y, x) in signed Q3.12 radians.
module atan2_seq #(
    parameter int PI_Q312      = 12868,
    parameter int HALF_PI_Q312 = 6434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] angle_out,
    output logic [15:0] atan_x,
    input  logic [15:0] atan_y
);

    typedef enum logic [1:0] {IDLE, DIV, ATAN, CORR} state_t;

    state_t        state_reg;
    logic          xneg_reg;
    logic          yneg_reg;
    logic          swap_reg;
    logic [14:0]   den_reg;
    logic [16:0]   rem_reg;
    logic [14:0]   q_reg;
    logic [3:0]    cnt_reg;
    logic [17:0]   r_reg;
    logic [15:0]   angle_reg;
    logic          done_reg;
    logic          busy_reg;

    logic [15:0]   x_abs;
    logic [15:0]   y_abs;
    logic          rem_ge;
    logic [16:0]   rem_sub;
    logic [17:0]   r_swap;
    logic [17:0]   r_xneg;
    logic [17:0]   r_final;

    // Operand magnitudes; the magnitude of -32768 saturates to 32767 so it fits in 15 bits
    always_comb begin
        x_abs = x_in;
        y_abs = y_in;
        if (x_in[15]) x_abs = (x_in == 16'h8000) ? 16'h7fff : (16'd0 - x_in);
        if (y_in[15]) y_abs = (y_in == 16'h8000) ? 16'h7fff : (16'd0 - y_in);
    end

    // One restoring-division step: subtract the denominator when the partial remainder allows it
    always_comb begin
        rem_ge  = (rem_reg >= {2'b00, den_reg});
        rem_sub = rem_ge ? (rem_reg - {2'b00, den_reg}) : rem_reg;
    end

    // Undo the octant fold first, then the x-sign fold, then the y-sign fold (order matters)
    always_comb begin
        r_swap  = swap_reg ? (18'(HALF_PI_Q312) - r_reg) : r_reg;
        r_xneg  = xneg_reg ? (18'(PI_Q312) - r_swap) : r_swap;
        r_final = yneg_reg ? (18'd0 - r_xneg) : r_xneg;
    end

    // The arctangent unit only sees the quotient while the result is being captured
    assign atan_x    = (state_reg == ATAN) ? {1'b0, q_reg} : 16'd0;
    assign angle_out = angle_reg;
    assign done      = done_reg;
    assign busy      = busy_reg;

    // Control FSM together with the divider datapath and the registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            xneg_reg  <= 1'b0;
            yneg_reg  <= 1'b0;
            swap_reg  <= 1'b0;
            den_reg   <= '0;
            rem_reg   <= '0;
            q_reg     <= '0;
            cnt_reg   <= '0;
            r_reg     <= '0;
            angle_reg <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        q_reg    <= '0;
                        cnt_reg  <= '0;
                        if (x_abs == 16'd0 && y_abs == 16'd0) begin
                            // Origin: no angle defined, report zero with no folding
                            xneg_reg  <= 1'b0;
                            yneg_reg  <= 1'b0;
                            swap_reg  <= 1'b0;
                            r_reg     <= '0;
                            den_reg   <= '0;
                            rem_reg   <= '0;
                            state_reg <= CORR;
                        end else begin
                            xneg_reg <= x_in[15];
                            yneg_reg <= y_in[15];
                            if (y_abs <= x_abs) begin
                                swap_reg <= 1'b0;
                                rem_reg  <= {2'b00, y_abs[14:0]};
                                den_reg  <= x_abs[14:0];
                            end else begin
                                swap_reg <= 1'b1;
                                rem_reg  <= {2'b00, x_abs[14:0]};
                                den_reg  <= y_abs[14:0];
                            end
                            state_reg <= DIV;
                        end
                    end
                end
                DIV: begin
                    // The remainder stays below den (< 2^15), so the shift never overflows 17 bits
                    q_reg   <= {q_reg[13:0], rem_ge};
                    rem_reg <= {rem_sub[15:0], 1'b0};
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == 4'd14) state_reg <= ATAN;
                end
                ATAN: begin
                    // Q1.14 -> Q3.12 by arithmetic shift right by two
                    r_reg     <= {{4{atan_y[15]}}, atan_y[15:2]};
                    state_reg <= CORR;
                end
                CORR: begin
                    angle_reg <= r_final[15:0];
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atan2_seq.sv
// Self-checking bench for atan2_seq. The bench models the external arctangent
// unit and predicts each angle from the octant and quadrant folding rules.
module tb_atan2_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic        busy;
    logic        done;
    logic [15:0] angle_out;
    logic [15:0] atan_x;
    logic [15:0] atan_y;

    int checks   = 0;
    int failures = 0;

    atan2_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x_in     (x_in),
        .y_in     (y_in),
        .busy     (busy),
        .done     (done),
        .angle_out(angle_out),
        .atan_x   (atan_x),
        .atan_y   (atan_y)
    );

    always #5 clk = ~clk;

    // External arctangent unit: atan(z) ~ pi/4*z + 0.273*z*(1-z), Q1.14 in and out
    function automatic int atan_fn(input int a);
        longint la;
        la = longint'(a);
        return int'(((la * 12868) >>> 14) + ((4473 * la * (16384 - la)) >>> 28));
    endfunction

    always_comb atan_y = 16'(atan_fn(int'($signed(atan_x))));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: fold to the first octant, divide, look up atan, then unfold
    function automatic int ref_q(input int x, input int y);
        int ax, ay;
        ax = (x < 0) ? ((x == -32768) ? 32767 : -x) : x;
        ay = (y < 0) ? ((y == -32768) ? 32767 : -y) : y;
        if (ax == 0 && ay == 0) return 0;
        if (ay <= ax) return (ay * 16384) / ax;
        return (ax * 16384) / ay;
    endfunction

    function automatic int ref_angle(input int x, input int y);
        int ax, ay, r;
        ax = (x < 0) ? ((x == -32768) ? 32767 : -x) : x;
        ay = (y < 0) ? ((y == -32768) ? 32767 : -y) : y;
        if (ax == 0 && ay == 0) return 0;
        r = atan_fn(ref_q(x, y)) >>> 2;
        if (ay > ax) r = 6434 - r;
        if (x < 0)   r = 12868 - r;
        if (y < 0)   r = -r;
        return r;
    endfunction

    // One operation: accept, optionally glitch start while busy, then check latency, busy, atan_x, result, hold
    task automatic run_op(input int x, input int y, input bit glitch);
        int exp_angle, exp_q, exp_lat, cycles, busy_cnt, seen_ax;
        bit got_done, zero;
        zero      = (x == 0 && y == 0);
        exp_angle = ref_angle(x, y);
        exp_q     = ref_q(x, y);
        exp_lat   = zero ? 1 : 17;
        x_in = 16'(x); y_in = 16'(y); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; x_in = 16'($urandom); y_in = 16'($urandom);
        cycles = 0; busy_cnt = 0; seen_ax = 0; got_done = 1'b0;
        while (cycles < 40 && !got_done) begin
            if (busy) busy_cnt++;
            if (atan_x != 16'd0) seen_ax = int'(atan_x);
            start = (glitch && cycles == 4);
            @(posedge clk); #1;
            cycles++;
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        $display("op x=%0d y=%0d angle=%0d expected=%0d latency=%0d", x, y, $signed(angle_out), exp_angle, cycles);
        check("done_seen", int'(got_done), 1);
        check("latency", cycles, exp_lat);
        check("angle", int'($signed(angle_out)), exp_angle);
        check("busy_at_done", int'(busy), 0);
        check("busy_cycles", busy_cnt, exp_lat);
        if (!zero) check("atan_x_q", seen_ax, exp_q);
        @(posedge clk); #1;
        check("done_pulse_width", int'(done), 0);
        check("angle_hold", int'($signed(angle_out)), exp_angle);
    endtask

    initial begin
        int cnt, pulses, xr, yr, exp_a;
        rst = 1'b1; start = 1'b1; x_in = 16'd100; y_in = 16'd50;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_angle", int'(angle_out), 0);
        check("rst_atan_x", int'(atan_x), 0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        // Directed cases: axes, origin, extremes, octant folding
        run_op(16384, 0, 1'b0);
        run_op(0, 100, 1'b0);
        run_op(0, -100, 1'b0);
        run_op(-100, 0, 1'b0);
        run_op(200, 100, 1'b0);
        run_op(-200, -100, 1'b0);
        run_op(0, 0, 1'b0);
        run_op(-32768, -32768, 1'b0);
        run_op(32767, -32768, 1'b0);
        run_op(-1, 32767, 1'b0);
        run_op(500, 300, 1'b1);

        // Randomized operands, with occasional start glitches while busy
        for (int i = 0; i < 40; i++) begin
            xr = int'($signed(16'($urandom)));
            yr = int'($signed(16'($urandom)));
            if (i % 10 == 3) xr = 0;
            if (i % 10 == 7) yr = -32768;
            run_op(xr, yr, ($urandom_range(0, 3) == 0));
        end

        // Start held high: back-to-back results every 18 cycles
        exp_a = ref_angle(300, -50);
        x_in = 16'd300; y_in = -16'sd50; start = 1'b1;
        cnt = 0;
        while (cnt < 40 && !done) begin @(posedge clk); #1; cnt++; end
        check("cont_first_done", int'(done), 1);
        for (int k = 0; k < 2; k++) begin
            cnt = 0;
            @(posedge clk); #1; cnt++;
            while (cnt < 40 && !done) begin @(posedge clk); #1; cnt++; end
            $display("continuous result=%0d interval=%0d", $signed(angle_out), cnt);
            check("cont_interval", cnt, 18);
            check("cont_angle", int'($signed(angle_out)), exp_a);
        end
        start = 1'b0;
        cnt = 0;
        @(posedge clk); #1;
        while (cnt < 40 && busy) begin @(posedge clk); #1; cnt++; end
        check("cont_drain", int'(busy), 0);

        // Reset during DIV aborts the operation
        run_op(0, 100, 1'b0);
        x_in = 16'd1000; y_in = 16'd300; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset mid-op busy=%0d done=%0d angle=%0d", busy, done, $signed(angle_out));
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_angle", int'(angle_out), 0);
        check("abort_atan_x", int'(atan_x), 0);
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_op(1000, 300, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/atan2_seq.md
ATAN2_SEQ -- requirements
Module: atan2_seq

Interface
REQ-001 SHALL have parameter PI_Q312, default 12868, meaning pi radians in signed Q3.12.
REQ-002 SHALL have parameter HALF_PI_Q312, default 6434, meaning pi/2 radians in signed Q3.12.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request pulse; operands sampled when accepted.
REQ-006 x_in  input  16  signed x operand, two's complement, any scale shared with y_in.
REQ-007 y_in  input  16  signed y operand, same scale as x_in.
REQ-008 busy  output  1  high while a computation is in flight.
REQ-009 done  output  1  one-cycle pulse, angle_out valid and updated.
REQ-010 angle_out  output  16  signed Q3.12 atan2(y,x) in radians, range [-PI_Q312, +PI_Q312].
REQ-011 atan_x  output  16  signed Q1.14 argument driven to an external combinational polynomial arctangent unit.
REQ-012 atan_y  input  16  signed Q1.14 result returned by that unit.

Function
REQ-013 SHALL implement states IDLE, DIV, ATAN, CORR; reset state IDLE.
REQ-014 IDLE: start=1 at an edge SHALL latch sign(x_in), sign(y_in), ax=|x_in|, ay=|y_in|, with |-32768| saturated to 32767.
REQ-015 At acceptance: ay<=ax -> num=ay, den=ax, swap=0; else num=ax, den=ay, swap=1; next state DIV.
REQ-016 At acceptance with x_in=0 and y_in=0: SHALL skip to CORR with r=0 and no quadrant correction, giving angle_out=0.
REQ-017 DIV: unsigned restoring division, 17-bit remainder, exactly 15 iterations, one per cycle, producing q=floor(num*16384/den) in [0,16384]; then ATAN.
REQ-018 atan_x SHALL equal q in ATAN and 0 in every other state.
REQ-019 ATAN: one cycle; SHALL register r=atan_y>>>2 (arithmetic, Q1.14 to Q3.12); then CORR.
REQ-020 CORR: one cycle; in order: swap -> r=HALF_PI_Q312-r; x negative -> r=PI_Q312-r; y negative -> r=-r; SHALL write r to angle_out, pulse done, return to IDLE.
REQ-021 y_in=0 with x_in<0 SHALL yield +PI_Q312 (never -PI_Q312).
REQ-022 Latency: start accepted at edge N -> angle_out and done valid after edge N+17 (18 cycles); zero-zero case after edge N+1.
REQ-023 busy SHALL be high from edge N until the edge that asserts done; busy=0 whenever done=1.
REQ-024 start while busy=1 SHALL be ignored without effect on the in-flight operation.
REQ-025 start in the done cycle SHALL be accepted (back-to-back throughput 18 cycles).
REQ-026 angle_out SHALL hold its value between done pulses; operands changing after acceptance SHALL not affect the result.
REQ-027 All intermediate arithmetic SHALL be wide enough that no overflow occurs for any 16-bit inputs.

Reset
REQ-028 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, angle_out=0, atan_x=0, overriding start.
REQ-029 rst asserted mid-operation SHALL abort it; no done pulse SHALL follow for that operation.

Verification
REQ-030 x_in=16384, y_in=0, start -> done after 18 cycles, angle_out=0 (atan_x=0 in ATAN), busy high 17 cycles.
REQ-031 x_in=0, y_in=100 -> angle_out=6434; x_in=0, y_in=-100 -> angle_out=-6434; x_in=-100, y_in=0 -> angle_out=12868.
REQ-032 x_in=200, y_in=100 -> atan_x=8192 in ATAN; angle_out=atan_y>>>2 from the external unit; x_in=-200, y_in=-100 -> angle_out=-(12868-(atan_y>>>2)).
REQ-033 x_in=0, y_in=0 -> done after 2 cycles, angle_out=0; x_in=-32768, y_in=-32768 -> atan_x=16384, swap=0, no overflow.
REQ-034 start pulsed at cycles 5 and 9 -> only first accepted; start held high continuously -> done every 18 cycles.
REQ-035 rst at cycle 8 of DIV -> next cycle busy=0, angle_out=0, no done; fresh start afterwards completes in 18 cycles.
